riscv_inst_encoder: RTL

//  Packs decoded RV32I fields (opcode, registers, functs, signed immediate) into 32-bit

---
 rtl/riscv_inst_encoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_inst_encoder.sv
// riscv_inst_encoder
//   Packs decoded RV32I fields into 32-bit instruction words for the instruction-memory
//   writer. Two-stage valid/ready pipeline:
//     S1 captures the field bundle and range-checks the immediate.
//     S2 holds the packed word (forced to NOP when the check failed).
//   Each word leaves tagged with a byte address from a counter that steps by 4 per
//   output transfer.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   clear                 reload address counter to BASE_ADDR (pipeline untouched)
//   in_valid / in_ready   input handshake for the field bundle
//   in_opcode .. in_imm   decoded fields; in_imm is signed (byte offset for B/J)
//   out_valid / out_ready output handshake
//   out_inst, out_addr    encoded word and its byte address
//   out_err               word failed its encode check (out_inst is NOP)
//   err_count             saturating count of errored words transferred

module riscv_inst_encoder #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP       = 32'h00000013;

    // Stage state
    logic              s1_valid_q;
    logic [6:0]        s1_opcode_q;
    logic [4:0]        s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]        s1_funct3_q;
    logic [6:0]        s1_funct7_q;
    logic [31:0]       s1_imm_q;
    logic              s1_err_q;
    logic              s2_valid_q;
    logic [31:0]       s2_inst_q;
    logic              s2_err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        err_count_q;

    // Handshake
    logic out_xfer, s1_advance, s1_load;

    always_comb begin
        out_xfer   = s2_valid_q && out_ready;
        s1_advance = s1_valid_q && (!s2_valid_q || out_xfer);
        in_ready   = !s1_valid_q || s1_advance;
        s1_load    = in_valid && in_ready;
    end

    // Immediate range checks on the incoming bundle. A signed value fits in N bits
    // when bits [31:N-1] are all equal.
    logic fits_i, fits_b, fits_j, in_shift, in_err;

    always_comb begin
        fits_i   = (&in_imm[31:11]) || !(|in_imm[31:11]);
        fits_b   = (&in_imm[31:12]) || !(|in_imm[31:12]);
        fits_j   = (&in_imm[31:20]) || !(|in_imm[31:20]);
        in_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
        in_err   = 1'b1;
        case (in_opcode)
            OP_REG:                     in_err = 1'b0;
            OP_IMM:                     in_err = in_shift ? (|in_imm[31:5]) : !fits_i;
            OP_LOAD, OP_JALR, OP_STORE: in_err = !fits_i;
            OP_BRANCH:                  in_err = !fits_b || in_imm[0];
            OP_LUI, OP_AUIPC:           in_err = |in_imm[11:0];
            OP_JAL:                     in_err = !fits_j || in_imm[0];
            default:                    in_err = 1'b1;
        endcase
    end

    // Pack the S1 bundle into an instruction word
    logic        s1_shift;
    logic [31:0] pack_inst;

    always_comb begin
        s1_shift  = (s1_funct3_q == 3'b001) || (s1_funct3_q == 3'b101);
        pack_inst = NOP;
        if (!s1_err_q) begin
            case (s1_opcode_q)
                OP_REG: pack_inst = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q,
                                     s1_opcode_q};
                OP_IMM: begin
                    if (s1_shift) begin
                        pack_inst = {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q,
                                     s1_rd_q, s1_opcode_q};
                    end else begin
                        pack_inst = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                                     s1_opcode_q};
                    end
                end
                OP_LOAD, OP_JALR: pack_inst = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q,
                                               s1_rd_q, s1_opcode_q};
                OP_STORE: pack_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                       s1_imm_q[4:0], s1_opcode_q};
                OP_BRANCH: pack_inst = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                                        s1_funct3_q, s1_imm_q[4:1], s1_imm_q[11],
                                        s1_opcode_q};
                OP_LUI, OP_AUIPC: pack_inst = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
                OP_JAL: pack_inst = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                                     s1_imm_q[19:12], s1_rd_q, s1_opcode_q};
                default: pack_inst = NOP;
            endcase
        end
    end

    // S1 field payload: only meaningful while s1_valid_q, so no reset needed
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_opcode_q <= in_opcode;
            s1_rd_q     <= in_rd;
            s1_rs1_q    <= in_rs1;
            s1_rs2_q    <= in_rs2;
            s1_funct3_q <= in_funct3;
            s1_funct7_q <= in_funct7;
            s1_imm_q    <= in_imm;
            s1_err_q    <= in_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_inst_q   <= '0;
            s2_err_q    <= 1'b0;
            addr_q      <= BASE_ADDR;
            err_count_q <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= 1'b1;
            end else if (s1_advance) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_advance) begin
                s2_valid_q <= 1'b1;
                s2_inst_q  <= pack_inst;
                s2_err_q   <= s1_err_q;
            end else if (out_xfer) begin
                s2_valid_q <= 1'b0;
            end

            // clear takes priority over the post-transfer increment
            if (clear) begin
                addr_q <= BASE_ADDR;
            end else if (out_xfer) begin
                addr_q <= addr_q + ADDR_W'(4);
            end

            if (out_xfer && s2_err_q && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_addr  = addr_q;
    assign out_err   = s2_err_q;
    assign err_count = err_count_q;

endmodule
